mem_responder: RTL

//  Memory-side responder for the custom CPU's two valid/ready channels: instruction fetch and data load/store.

---
 rtl/mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one shared single-port word RAM behind the CPU fetch and
// load/store valid/ready channels. It serves one request at a time, and data requests win over fetches.
module mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] cnt_inst,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store
);
  // state  | meaning
  // IDLE   | ready for a request; stores complete here in one edge
  // I_WAIT | fetch accepted, latency counter running
  // I_RESP | Instruction valid, waiting for Inst_Ready
  // D_WAIT | load accepted, latency counter running
  // D_RESP | Read_data valid, waiting for Read_data_Ready
  typedef enum logic [2:0] {IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP} state_t;

  // With LATENCY==1 the wait states are skipped, so the wrapped value is never used.
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 2);

  logic [31:0]           mem [2**ADDR_WIDTH];
  state_t                state_q, state_d;
  logic [7:0]            lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, rd_idx;
  logic                  rd_en;
  logic [31:0]           resp_q;
  logic [31:0]           cnt_inst_q, cnt_load_q, cnt_store_q;
  logic [ADDR_WIDTH-1:0] a_idx, p_idx;
  logic                  wr_hs, rd_hs, if_hs;
  logic                  unused_addr_bits;

  assign a_idx = Address[ADDR_WIDTH+1:2];
  assign p_idx = PC[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                              Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign Mem_Req_Ready  = (state_q == IDLE) & ~rst;
  assign Inst_Req_Ready = Mem_Req_Ready & ~MemRead & ~MemWrite;

  // When MemRead and MemWrite are both high, the request is a store only.
  assign wr_hs = Mem_Req_Ready & MemWrite;
  assign rd_hs = Mem_Req_Ready & MemRead & ~MemWrite;
  assign if_hs = Inst_Req_Ready & Inst_Req_Valid;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      IDLE: begin
        if (rd_hs || if_hs) begin
          idx_d = rd_hs ? a_idx : p_idx;
          if (LATENCY == 1) begin
            state_d = rd_hs ? D_RESP : I_RESP;
            rd_en   = 1'b1;
            rd_idx  = idx_d;
          end else begin
            state_d = rd_hs ? D_WAIT : I_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      I_WAIT, D_WAIT: begin
        if (lat_q == 8'd0) begin
          state_d = (state_q == I_WAIT) ? I_RESP : D_RESP;
          rd_en   = 1'b1;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      I_RESP: if (Inst_Ready) state_d = IDLE;
      D_RESP: if (Read_data_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      idx_q       <= '0;
      resp_q      <= '0;
      cnt_inst_q  <= '0;
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      if (rd_en) resp_q <= mem[rd_idx];
      if (if_hs) cnt_inst_q  <= cnt_inst_q + 32'd1;
      if (rd_hs) cnt_load_q  <= cnt_load_q + 32'd1;
      if (wr_hs) cnt_store_q <= cnt_store_q + 32'd1;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) mem[a_idx][8*b +: 8] <= Write_data[8*b +: 8];
      end
    end
  end

  assign Inst_Valid      = (state_q == I_RESP) & ~rst;
  assign Read_data_Valid = (state_q == D_RESP) & ~rst;
  assign Instruction     = Inst_Valid ? resp_q : '0;
  assign Read_data       = Read_data_Valid ? resp_q : '0;
  assign cnt_inst        = rst ? '0 : cnt_inst_q;
  assign cnt_load        = rst ? '0 : cnt_load_q;
  assign cnt_store       = rst ? '0 : cnt_store_q;

endmodule
